sram_rw_arbiter: RTL and testbench

SRAM_RW_ARBITER -- requirements
Module: sram_rw_arbiter

---
 rtl/sram_arb_pkg.sv | 13 +
 rtl/sram_rw_arbiter_if.sv | 40 ++++
 rtl/sram_rw_arbiter_rr_arb2.sv | 33 +++
 rtl/sram_rw_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_rw_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the two-port SRAM read/write arbiter.
// The optional power-up zero-fill is enabled by defining SRAM_ARB_INIT_EN.
package sram_arb_pkg;

  localparam int ADDR_W_DEFAULT = 10;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sram_rw_arbiter_if.sv
// Client-side bus of the arbiter: two request ports and their read responses.
// master = requesting client, slave = arbiter.
interface sram_rw_arbiter_if #(
  parameter int ADDR_W = sram_arb_pkg::ADDR_W_DEFAULT,
  parameter int DATA_W = sram_arb_pkg::DATA_W_DEFAULT
) ();

  logic                req0_valid;
  logic                req0_ready;
  logic                req0_write;
  logic [ADDR_W-1:0]   req0_addr;
  logic [DATA_W/8-1:0] req0_wmask;
  logic [DATA_W-1:0]   req0_wdata;
  logic                resp0_valid;
  logic [DATA_W-1:0]   resp0_rdata;

  logic                req1_valid;
  logic                req1_ready;
  logic                req1_write;
  logic [ADDR_W-1:0]   req1_addr;
  logic [DATA_W/8-1:0] req1_wmask;
  logic [DATA_W-1:0]   req1_wdata;
  logic                resp1_valid;
  logic [DATA_W-1:0]   resp1_rdata;

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wmask, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wmask, req1_wdata,
    input  req0_ready, resp0_valid, resp0_rdata,
    input  req1_ready, resp1_valid, resp1_rdata
  );

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wmask, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wmask, req1_wdata,
    output req0_ready, resp0_valid, resp0_rdata,
    output req1_ready, resp1_valid, resp1_rdata
  );

endinterface

// File: rtl/sram_rw_arbiter_rr_arb2.sv
// Two-way round-robin picker: one-hot grant, pointer moves only when a grant is issued.
module rr_arb2 (
  input  logic       RW0_clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;  // port granted most recently

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge RW0_clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Arbitrates two request ports onto a single-port (RW0) SRAM macro.
// Define SRAM_ARB_INIT_EN to zero-fill the whole macro after reset before serving requests.
module sram_rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int NUM_WORDS = 1 << ADDR_W
) (
  input  logic                RW0_clk,
  input  logic                rst,
  sram_rw_arbiter_if.slave    bus,
  output logic                sram_en,
  output logic                sram_wmode,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W/8-1:0] sram_wmask,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int MASK_W = DATA_W / 8;

  if (NUM_WORDS != (1 << ADDR_W)) begin : g_bad_depth
    $error("NUM_WORDS must equal 2**ADDR_W");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of 8");
  end

  arb_state_e state_q;
  logic       run;
  logic [1:0] gnt;
  logic [1:0] resp_v_q;

`ifdef SRAM_ARB_INIT_EN
  arb_state_e        state_d;
  logic [ADDR_W-1:0] init_cnt_q;
  logic              init_active;

  always_ff @(posedge RW0_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && init_cnt_q == ADDR_W'(NUM_WORDS - 1)) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge RW0_clk or posedge rst) begin
    if (rst) begin
      init_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      init_cnt_q <= init_cnt_q + 1'b1;
    end
  end

  assign init_active = (state_q == ST_INIT) && !rst;
`else
  assign state_q = ST_RUN;
`endif

  // Outputs stay quiet for the whole time reset is held, not just after its first edge.
  assign run = (state_q == ST_RUN) && !rst;

  rr_arb2 u_rr_arb2 (
    .RW0_clk (RW0_clk),
    .rst     (rst),
    .en      (run),
    .req     ({bus.req1_valid, bus.req0_valid}),
    .gnt     (gnt)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  // NOTE: every output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (gnt[0]) begin
      sram_en    = 1'b1;
      sram_wmode = bus.req0_write;
      sram_addr  = bus.req0_addr;
      sram_wmask = bus.req0_wmask;
      sram_wdata = bus.req0_wdata;
    end else if (gnt[1]) begin
      sram_en    = 1'b1;
      sram_wmode = bus.req1_write;
      sram_addr  = bus.req1_addr;
      sram_wmask = bus.req1_wmask;
      sram_wdata = bus.req1_wdata;
    end
`ifdef SRAM_ARB_INIT_EN
    if (init_active) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_cnt_q;
      sram_wmask = {MASK_W{1'b1}};
      sram_wdata = '0;
    end
`endif
  end

  // The macro returns read data one cycle after the access, so only the valid flag is registered.
  always_ff @(posedge RW0_clk or posedge rst) begin
    if (rst) begin
      resp_v_q <= 2'b00;
    end else begin
      resp_v_q[0] <= gnt[0] & ~bus.req0_write;
      resp_v_q[1] <= gnt[1] & ~bus.req1_write;
    end
  end

  assign bus.resp0_valid = resp_v_q[0];
  assign bus.resp1_valid = resp_v_q[1];
  assign bus.resp0_rdata = sram_rdata;
  assign bus.resp1_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Self-checking bench for sram_rw_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model. Build with SRAM_ARB_INIT_EN to cover the zero-fill phase.
module tb_sram_rw_arbiter;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int NUM_WORDS = 1024;

  logic              RW0_clk;
  logic              rst;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [3:0]        sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  sram_rw_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS)) dut (
    .RW0_clk    (RW0_clk),
    .rst        (rst),
    .bus        (bus.slave),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial RW0_clk = 1'b0;
  always #5 RW0_clk = ~RW0_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural SRAM macro: one-cycle read latency, byte-masked writes, random power-up contents.
  logic [DATA_W-1:0] sram_mem [NUM_WORDS];
  initial begin
    for (int i = 0; i < NUM_WORDS; i++) sram_mem[i] = $urandom;
    sram_rdata = '0;
    forever begin
      @(posedge RW0_clk);
      if (sram_en) begin
        if (sram_wmode) begin
          for (int b = 0; b < 4; b++)
            if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
        end else begin
          sram_rdata <= sram_mem[sram_addr];
        end
      end
    end
  end

  // Reference model: tracks what memory must hold, who was granted last, and expected responses.
  logic [DATA_W-1:0] mdl_mem   [NUM_WORDS];
  bit                mdl_known [NUM_WORDS];

  initial begin
    int          last;
    int          init_cnt;
    bit          pend_v [2];
    logic [31:0] pend_d [2];
    bit          pend_k [2];
    bit          in_init;
    int          w;
    bit          v [2];
    bit          wr [2];
    logic [9:0]  a [2];
    logic [3:0]  m [2];
    logic [31:0] d [2];
    last = 1;
    init_cnt = 0;
    for (int i = 0; i < 2; i++) begin pend_v[i] = 0; pend_k[i] = 0; pend_d[i] = '0; end
    for (int i = 0; i < NUM_WORDS; i++) begin mdl_known[i] = 0; mdl_mem[i] = '0; end
    forever begin
      @(negedge RW0_clk);
      w = -1;
      in_init = 0;
      if (rst) begin
        last = 1;
        init_cnt = 0;
        pend_v[0] = 0;
        pend_v[1] = 0;
        check("m_rst_ready0", bus.req0_ready, 0);
        check("m_rst_ready1", bus.req1_ready, 0);
        check("m_rst_en", sram_en, 0);
        check("m_rst_resp0", bus.resp0_valid, 0);
        check("m_rst_resp1", bus.resp1_valid, 0);
      end else begin
        v[0] = bus.req0_valid; wr[0] = bus.req0_write; a[0] = bus.req0_addr;
        m[0] = bus.req0_wmask; d[0] = bus.req0_wdata;
        v[1] = bus.req1_valid; wr[1] = bus.req1_write; a[1] = bus.req1_addr;
        m[1] = bus.req1_wmask; d[1] = bus.req1_wdata;
`ifdef SRAM_ARB_INIT_EN
        in_init = (init_cnt < NUM_WORDS);
`endif
        check("m_resp0_valid", bus.resp0_valid, pend_v[0]);
        check("m_resp1_valid", bus.resp1_valid, pend_v[1]);
        if (pend_v[0] && pend_k[0]) check("m_resp0_rdata", bus.resp0_rdata, pend_d[0]);
        if (pend_v[1] && pend_k[1]) check("m_resp1_rdata", bus.resp1_rdata, pend_d[1]);
        if (in_init) begin
          check("m_init_ready0", bus.req0_ready, 0);
          check("m_init_ready1", bus.req1_ready, 0);
          check("m_init_en", sram_en, 1);
          check("m_init_wmode", sram_wmode, 1);
          check("m_init_addr", sram_addr, init_cnt);
          check("m_init_wmask", sram_wmask, 4'hF);
          check("m_init_wdata", sram_wdata, 0);
        end else begin
          if (v[0] && v[1]) w = 1 - last;
          else if (v[0]) w = 0;
          else if (v[1]) w = 1;
          check("m_ready0", bus.req0_ready, w == 0);
          check("m_ready1", bus.req1_ready, w == 1);
          check("m_en", sram_en, w >= 0);
          if (w >= 0) begin
            check("m_addr", sram_addr, a[w]);
            check("m_wmode", sram_wmode, wr[w]);
            if (wr[w]) begin
              check("m_wmask", sram_wmask, m[w]);
              check("m_wdata", sram_wdata, d[w]);
            end
          end
        end
      end
      @(posedge RW0_clk);
      if (!rst) begin
        pend_v[0] = 0;
        pend_v[1] = 0;
        if (in_init) begin
          mdl_mem[init_cnt] = '0;
          mdl_known[init_cnt] = 1;
          init_cnt++;
        end else if (w >= 0) begin
          last = w;
          if (wr[w]) begin
            for (int b = 0; b < 4; b++)
              if (m[w][b]) mdl_mem[a[w]][8*b +: 8] = d[w][8*b +: 8];
            if (m[w] == 4'hF) mdl_known[a[w]] = 1;
          end else begin
            pend_v[w] = 1;
            pend_d[w] = mdl_mem[a[w]];
            pend_k[w] = mdl_known[a[w]];
          end
        end
      end
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  task automatic set_req(input int p, input bit v, input bit wr, input logic [9:0] a,
                         input logic [3:0] m, input logic [31:0] d);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_write = wr; bus.req0_addr = a;
      bus.req0_wmask = m; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_write = wr; bus.req1_addr = a;
      bus.req1_wmask = m; bus.req1_wdata = d;
    end
  endtask

  task automatic idle();
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
  endtask

  task automatic step();
    @(posedge RW0_clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    idle();
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  task automatic wait_run();
`ifdef SRAM_ARB_INIT_EN
    repeat (NUM_WORDS) step();
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    do_reset(3);

`ifdef SRAM_ARB_INIT_EN
    begin
      int k;
      set_req(0, 1, 0, 10'h3FF, 4'h0, '0);
      k = 0;
      @(negedge RW0_clk);
      while (!bus.req0_ready && k < 2000) begin
        if (k == 500) check("init_addr_500", sram_addr, 500);
        step();
        k++;
        @(negedge RW0_clk);
      end
      check("init_len", k, 1024);
      step();
      idle();
      @(negedge RW0_clk);
      check("init_rd3ff_valid", bus.resp0_valid, 1);
      check("init_rd3ff_data", bus.resp0_rdata, 32'h0);
      step();
      do_reset(2);
      repeat (500) step();
      @(negedge RW0_clk);
      check("init_cnt_500", sram_addr, 500);
      step();
      do_reset(2);
      @(negedge RW0_clk);
      check("init_restart_addr", sram_addr, 0);
      set_req(0, 1, 0, 10'h3FF, 4'h0, '0);
      k = 0;
      while (!bus.req0_ready && k < 2000) begin
        step();
        k++;
        @(negedge RW0_clk);
      end
      check("init_len_again", k, 1024);
      step();
      idle();
      step();
    end
`else
    @(negedge RW0_clk);
    check("first_cycle_en", sram_en, 0);
`endif

    // Single write then read on port 0
    set_req(0, 1, 1, 10'h005, 4'hF, 32'hDEADBEEF);
    @(negedge RW0_clk);
    check("wr5_ready0", bus.req0_ready, 1);
    step();
    set_req(0, 1, 0, 10'h005, 4'h0, '0);
    @(negedge RW0_clk);
    check("rd5_ready0", bus.req0_ready, 1);
    check("wr_no_resp", bus.resp0_valid, 0);
    step();
    idle();
    @(negedge RW0_clk);
    check("rd5_valid", bus.resp0_valid, 1);
    check("rd5_data", bus.resp0_rdata, 32'hDEADBEEF);
    step();
    @(negedge RW0_clk);
    check("rd5_one_pulse", bus.resp0_valid, 0);

    // Byte mask merge
    set_req(0, 1, 1, 10'h007, 4'hF, 32'hFFFFFFFF);
    step();
    set_req(0, 1, 1, 10'h007, 4'h2, 32'h00000000);
    step();
    set_req(0, 1, 0, 10'h007, 4'h0, '0);
    step();
    idle();
    @(negedge RW0_clk);
    check("mask_data", bus.resp0_rdata, 32'hFFFF00FF);
    step();

    // Contention right after reset: grants alternate starting with port 0
    do_reset(2);
    wait_run();
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1, 0, 10'(8'h20 + i), 4'h0, '0);
      set_req(1, 1, 0, 10'(8'h30 + i), 4'h0, '0);
      @(negedge RW0_clk);
      check($sformatf("rr_gnt0_%0d", i), bus.req0_ready, (i % 2) == 0);
      check($sformatf("rr_gnt1_%0d", i), bus.req1_ready, (i % 2) == 1);
      step();
    end
    idle();
    step();

    // Port 1 write followed immediately by port 0 read of the same word
    set_req(1, 1, 1, 10'h010, 4'hF, 32'h12345678);
    step();
    set_req(1, 0, 0, '0, '0, '0);
    set_req(0, 1, 0, 10'h010, 4'h0, '0);
    @(negedge RW0_clk);
    check("wtr_resp1_a", bus.resp1_valid, 0);
    step();
    idle();
    @(negedge RW0_clk);
    check("wtr_resp0_valid", bus.resp0_valid, 1);
    check("wtr_resp0_data", bus.resp0_rdata, 32'h12345678);
    check("wtr_resp1_b", bus.resp1_valid, 0);
    step();

    // Reset while a read response is pending
    set_req(0, 1, 0, 10'h005, 4'h0, '0);
    step();
    rst = 1'b1;
    idle();
    @(negedge RW0_clk);
    check("rst_drops_resp", bus.resp0_valid, 0);
    step();
    rst = 1'b0;
    wait_run();

    // Randomized traffic over a small address window
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(2);
        wait_run();
      end
      for (int p = 0; p < 2; p++)
        set_req(p, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                10'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
      step();
    end
    idle();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
